multi_bank_port_arbiter: RTL and testbench
==========================================

# multi_bank_port_arbiter

Round-robin arbiter that shares the two ports (A and B) of the banked dual-port memory among `NUM_REQ` requesters. It grants up to two requests per cycle and splits each address into bank select and in-bank address. It drives registered memory commands, prevents same-address conflicts between ports, and returns read data to the owning requester with a tag pipeline. It sits between the requester fabric and the multi-bank memory, with both memory clocks tied to `i_clk`.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `ADDR_TOTAL`, default 10: full address width. The top 2 bits select the bank; the low `ADDR_TOTAL-2` bits are the in-bank address.
- `WIDTH`, default 8: data width.

Ports (one clock; reset is asynchronous and active-low):
- `i_clk`, in, 1: the only clock.
- `i_rst_n`, in, 1: asynchronous active-low reset.
- `i_req`, in, `NUM_REQ`: request per requester. Held high with stable fields until granted.
- `i_we`, in, `NUM_REQ`: 1 = write, 0 = read.
- `i_addr`, in, `NUM_REQ*ADDR_TOTAL`: flattened full addresses. Requester r uses slice r.
- `i_din`, in, `NUM_REQ*WIDTH`: flattened write data.
- `o_gnt`, out, `NUM_REQ`: combinational grant, at most two bits set. The request is accepted in the cycle `o_gnt[r]` is high.
- `o_rvalid`, out, `NUM_REQ`: read data valid for requester r.
- `o_rdata`, out, `NUM_REQ*WIDTH`: flattened read data. Slice r is meaningful only while `o_rvalid[r]` is high.
- `o_en_a`, `o_we_a`, out, 1 each: port A enable and write enable (registered).
- `o_bank_sel_a`, out, 2: port A bank select (registered).
- `o_addr_a`, out, `ADDR_TOTAL-2`: port A in-bank address (registered).
- `o_din_a`, out, `WIDTH`: port A write data (registered).
- `o_en_b`, `o_we_b`, `o_bank_sel_b`, `o_addr_b`, `o_din_b`: port B equivalents of the port A outputs.
- `i_dout_a`, `i_dout_b`, in, `WIDTH` each: memory read data, valid one cycle after the command cycle.

## Operation
- Round-robin pointer `rr_ptr` (width `clog2(NUM_REQ)`), reset value 0.
- Each cycle, scan requesters cyclically starting at `rr_ptr`:
  - The first active requester is candidate A.
  - The next active requester after A, in cyclic order, is candidate B.
- Conflict rule: B is not granted if its full address equals A's and at least one of the two is a write. B then waits and keeps requesting.
- `o_gnt` is high for the granted candidates only. A requester is never granted on both ports.
- Pointer update:
  - 2 grants: `rr_ptr` = (B index + 1) mod `NUM_REQ`.
  - 1 grant: `rr_ptr` = (A index + 1) mod `NUM_REQ`.
  - 0 grants: `rr_ptr` unchanged.
- Command stage (registered at the clock edge):
  - For each port: `o_en_x` = granted, `o_we_x` = `i_we` of the grantee.
  - `o_bank_sel_x` = addr[`ADDR_TOTAL-1`:`ADDR_TOTAL-2`], `o_addr_x` = addr[`ADDR_TOTAL-3`:0].
  - `o_din_x` = din of the grantee.
  - An ungranted port has all command outputs at 0.
- Tag stage: for each port, register {valid-read, requester index} alongside the command, then advance it one more stage.
- Return: `o_rvalid[r]` = 1 when a tag at the return stage is a valid read for r. `o_rdata` slice r = `i_dout_a` or `i_dout_b` of the matching port.
  - Both ports can return in the same cycle, always to different requesters.
- Writes produce no `o_rvalid`.

## Timing
- Cycle t: request seen, `o_gnt` high in the same cycle.
- Cycle t+1: memory command on the port outputs.
- Cycle t+2: `o_rvalid`/`o_rdata` for reads. Read latency from grant is 2 cycles.
- Full throughput: 2 accepted requests per cycle, with no bubbles between back-to-back grants.
- Reset values, asynchronous on `i_rst_n` low:
  - `rr_ptr` = 0 and all tag valids = 0.
  - `o_en_a/b`, `o_we_a/b`, `o_bank_sel_a/b`, `o_addr_a/b`, `o_din_a/b` = 0.
  - `o_rvalid` = 0 and `o_rdata` = 0.
  - `o_gnt` = 0 while reset is asserted.
- Reset mid-operation: in-flight commands and reads are dropped and never produce `o_rvalid`. Arbitration resumes with `rr_ptr` = 0 on the first cycle after deassertion.
- Same-address write by A with read by B is serialized: B is granted no earlier than the next cycle and reads the written data.
- Different addresses in the same bank are both granted; the memory is true dual-port.
- Single active requester: granted on port A every cycle; port B stays idle.
- `rr_ptr` wraps from `NUM_REQ-1` to 0.

## Test plan
- Reset with `i_req`=4'b1111 held: `o_gnt`=0 and all port outputs 0. After release with `rr_ptr`=0, the first cycle gives `o_gnt`=4'b0011 and the next cycle gives 4'b1100.
- Requester 2 writes 0xA5 to address 0x1C3: next cycle `o_en_a`=1, `o_we_a`=1, `o_bank_sel_a`=2'b01, `o_addr_a`=8'hC3, `o_din_a`=0xA5. A later read of 0x1C3 by requester 0 gives `o_rvalid[0]`=1 with `o_rdata[0]`=0xA5, 2 cycles after its grant.
- Requesters 1 and 3 both read different preloaded addresses in the same cycle: both are granted, and 2 cycles later `o_rvalid`=4'b1010 with the correct data in each slice.
- Requester 0 writes 0x3C and requester 1 reads the same address 0x005 in the same cycle: the grant cycle gives `o_gnt`=4'b0001. The next cycle gives `o_gnt[1]`=1, and the read returns 0x3C.
- Only requester 3 requests for 4 cycles: `o_gnt`=4'b1000 every cycle, `o_en_b`=0, and `rr_ptr` wraps to 0 each cycle.
- Issue a read, then assert `i_rst_n`=0 one cycle after the grant: no `o_rvalid` appears, and all outputs read 0 until release.

Source files
------------

// File: rtl/multi_bank_port_arbiter.sv
// rtl/multi_bank_port_arbiter.sv - round-robin two-port arbiter for a banked dual-port memory
module multi_bank_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_TOTAL = 10,
    parameter int WIDTH      = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ-1:0]            i_we,
    input  logic [NUM_REQ*ADDR_TOTAL-1:0] i_addr,
    input  logic [NUM_REQ*WIDTH-1:0]      i_din,
    output logic [NUM_REQ-1:0]            o_gnt,
    output logic [NUM_REQ-1:0]            o_rvalid,
    output logic [NUM_REQ*WIDTH-1:0]      o_rdata,
    output logic                          o_en_a,
    output logic                          o_we_a,
    output logic [1:0]                    o_bank_sel_a,
    output logic [ADDR_TOTAL-3:0]         o_addr_a,
    output logic [WIDTH-1:0]              o_din_a,
    output logic                          o_en_b,
    output logic                          o_we_b,
    output logic [1:0]                    o_bank_sel_b,
    output logic [ADDR_TOTAL-3:0]         o_addr_b,
    output logic [WIDTH-1:0]              o_din_b,
    input  logic [WIDTH-1:0]              i_dout_a,
    input  logic [WIDTH-1:0]              i_dout_b
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      rr_ptr_nxt;
    logic                  found_a;
    logic                  found_b;
    logic                  grant_b;
    logic [PTR_W-1:0]      idx_a;
    logic [PTR_W-1:0]      idx_b;
    logic [ADDR_TOTAL-1:0] sel_addr_a;
    logic [ADDR_TOTAL-1:0] sel_addr_b;
    logic                  sel_we_a;
    logic                  sel_we_b;
    logic [WIDTH-1:0]      sel_din_a;
    logic [WIDTH-1:0]      sel_din_b;

    // In-flight tags: stage 1 rides with the command, stage 2 lines up with memory data
    logic                  tag1_vld_a, tag1_vld_b, tag2_vld_a, tag2_vld_b;
    logic [PTR_W-1:0]      tag1_idx_a, tag1_idx_b, tag2_idx_a, tag2_idx_b;

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
        logic [PTR_W:0] sum;
        sum = {1'b0, idx} + (PTR_W+1)'(1);
        if (sum >= (PTR_W+1)'(NUM_REQ)) sum = '0;
        return sum[PTR_W-1:0];
    endfunction

    // Cyclic scan from rr_ptr: first active requester is A, the next one is B
    always_comb begin
        found_a = 1'b0;
        found_b = 1'b0;
        idx_a   = '0;
        idx_b   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            logic [PTR_W:0] pos;
            pos = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (pos >= (PTR_W+1)'(NUM_REQ)) pos = pos - (PTR_W+1)'(NUM_REQ);
            if (i_req[pos[PTR_W-1:0]]) begin
                if (!found_a) begin
                    found_a = 1'b1;
                    idx_a   = pos[PTR_W-1:0];
                end else if (!found_b) begin
                    found_b = 1'b1;
                    idx_b   = pos[PTR_W-1:0];
                end
            end
        end
    end

    // Candidate fields, conflict filtering of B, grant vector and pointer advance
    always_comb begin
        sel_addr_a = i_addr[idx_a*ADDR_TOTAL +: ADDR_TOTAL];
        sel_addr_b = i_addr[idx_b*ADDR_TOTAL +: ADDR_TOTAL];
        sel_we_a   = i_we[idx_a];
        sel_we_b   = i_we[idx_b];
        sel_din_a  = i_din[idx_a*WIDTH +: WIDTH];
        sel_din_b  = i_din[idx_b*WIDTH +: WIDTH];
        // A write racing any access to the same word is deferred so B sees the result
        grant_b    = found_b && !((sel_addr_a == sel_addr_b) && (sel_we_a || sel_we_b));
        o_gnt      = '0;
        if (i_rst_n) begin
            if (found_a) o_gnt[idx_a] = 1'b1;
            if (grant_b) o_gnt[idx_b] = 1'b1;
        end
        if (grant_b)      rr_ptr_nxt = next_idx(idx_b);
        else if (found_a) rr_ptr_nxt = next_idx(idx_a);
        else              rr_ptr_nxt = rr_ptr;
    end

    // Pointer, registered memory commands and the two-stage tag pipeline
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr       <= '0;
            o_en_a       <= 1'b0;
            o_we_a       <= 1'b0;
            o_bank_sel_a <= '0;
            o_addr_a     <= '0;
            o_din_a      <= '0;
            o_en_b       <= 1'b0;
            o_we_b       <= 1'b0;
            o_bank_sel_b <= '0;
            o_addr_b     <= '0;
            o_din_b      <= '0;
            tag1_vld_a   <= 1'b0;
            tag1_vld_b   <= 1'b0;
            tag2_vld_a   <= 1'b0;
            tag2_vld_b   <= 1'b0;
            tag1_idx_a   <= '0;
            tag1_idx_b   <= '0;
            tag2_idx_a   <= '0;
            tag2_idx_b   <= '0;
        end else begin
            rr_ptr       <= rr_ptr_nxt;
            o_en_a       <= found_a;
            o_we_a       <= found_a & sel_we_a;
            o_bank_sel_a <= found_a ? sel_addr_a[ADDR_TOTAL-1:ADDR_TOTAL-2] : 2'b00;
            o_addr_a     <= found_a ? sel_addr_a[ADDR_TOTAL-3:0] : '0;
            o_din_a      <= found_a ? sel_din_a : '0;
            o_en_b       <= grant_b;
            o_we_b       <= grant_b & sel_we_b;
            o_bank_sel_b <= grant_b ? sel_addr_b[ADDR_TOTAL-1:ADDR_TOTAL-2] : 2'b00;
            o_addr_b     <= grant_b ? sel_addr_b[ADDR_TOTAL-3:0] : '0;
            o_din_b      <= grant_b ? sel_din_b : '0;
            tag1_vld_a   <= found_a & ~sel_we_a;
            tag1_vld_b   <= grant_b & ~sel_we_b;
            tag1_idx_a   <= idx_a;
            tag1_idx_b   <= idx_b;
            tag2_vld_a   <= tag1_vld_a;
            tag2_vld_b   <= tag1_vld_b;
            tag2_idx_a   <= tag1_idx_a;
            tag2_idx_b   <= tag1_idx_b;
        end
    end

    // Route returning memory data to the requester that owns each tag
    always_comb begin
        o_rvalid = '0;
        o_rdata  = '0;
        if (tag2_vld_a) begin
            o_rvalid[tag2_idx_a]               = 1'b1;
            o_rdata[tag2_idx_a*WIDTH +: WIDTH] = i_dout_a;
        end
        if (tag2_vld_b) begin
            o_rvalid[tag2_idx_b]               = 1'b1;
            o_rdata[tag2_idx_b*WIDTH +: WIDTH] = i_dout_b;
        end
    end

endmodule

// File: tb/tb_multi_bank_port_arbiter.sv
// tb/tb_multi_bank_port_arbiter.sv - scoreboard bench for multi_bank_port_arbiter
module tb_multi_bank_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, we;
    logic [39:0] addr;
    logic [31:0] din;
    logic [3:0]  gnt, rvalid;
    logic [31:0] rdata;
    logic        en_a, we_a, en_b, we_b;
    logic [1:0]  bank_a, bank_b;
    logic [7:0]  addr_a, addr_b, din_a, din_b;
    logic [7:0]  dout_a = 8'h00;
    logic [7:0]  dout_b = 8'h00;
    logic [7:0]  mem [0:1023];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int         r;
        logic [7:0] d;
        int         due;
    } exp_t;
    exp_t sbq[$];

    multi_bank_port_arbiter dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_addr(addr), .i_din(din),
        .o_gnt(gnt), .o_rvalid(rvalid), .o_rdata(rdata),
        .o_en_a(en_a), .o_we_a(we_a), .o_bank_sel_a(bank_a), .o_addr_a(addr_a), .o_din_a(din_a),
        .o_en_b(en_b), .o_we_b(we_b), .o_bank_sel_b(bank_b), .o_addr_b(addr_b), .o_din_b(din_b),
        .i_dout_a(dout_a), .i_dout_b(dout_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Banked true dual-port memory, one-cycle registered read
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[10'h2A0] <= 8'h11;
            mem[10'h2FF] <= 8'h22;
        end
        if (en_a) begin
            if (we_a) mem[{bank_a, addr_a}] <= din_a;
            else      dout_a <= mem[{bank_a, addr_a}];
        end
        if (en_b) begin
            if (we_b) mem[{bank_b, addr_b}] <= din_b;
            else      dout_b <= mem[{bank_b, addr_b}];
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic w, input logic [9:0] a, input logic [7:0] d);
        req[r]           = 1'b1;
        we[r]            = w;
        addr[r*10 +: 10] = a;
        din[r*8 +: 8]    = d;
    endtask

    task automatic push(input int r, input logic [7:0] d);
        exp_t e;
        e.r   = r;
        e.d   = d;
        e.due = cyc + 2;
        sbq.push_back(e);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_gnt"}, gnt, 4'h0);
        chk({name, "_port_a"}, {en_a, we_a, bank_a, addr_a, din_a}, 20'h0);
        chk({name, "_port_b"}, {en_b, we_b, bank_b, addr_b, din_b}, 20'h0);
        chk({name, "_ret"}, {rvalid, rdata}, 36'h0);
    endtask

    // Monitor: every read return is popped against the scoreboard
    initial begin
        int hit;
        int i;
        forever begin
            @(negedge clk);
            for (int r = 0; r < 4; r++) begin
                if (rvalid[r]) begin
                    hit = -1;
                    for (int k = 0; k < sbq.size(); k++)
                        if (sbq[k].r == r && hit < 0) hit = k;
                    if (hit < 0) begin
                        chk("unexpected_rvalid", rvalid[r], 1'b0);
                    end else begin
                        chk("rdata", rdata[r*8 +: 8], sbq[hit].d);
                        chk("read_latency", cyc, sbq[hit].due);
                        sbq.delete(hit);
                    end
                end
            end
            i = 0;
            while (i < sbq.size()) begin
                if (sbq[i].due < cyc) begin
                    chk("missing_rvalid", rvalid[sbq[i].r], 1'b1);
                    sbq.delete(i);
                end else begin
                    i++;
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        we    = '0;
        addr  = '0;
        din   = '0;
        for (int r = 0; r < 4; r++) set_req(r, 1'b1, 10'h300 + 10'(r), 8'h10 + 8'(r));
        repeat (3) step();
        chk_all_zero("reset");

        rst_n = 1'b1;
        #1;
        chk("first_gnt", gnt, 4'b0011);
        step();
        req[1:0] = 2'b00;
        #1;
        chk("second_gnt", gnt, 4'b1100);
        chk("cmd_a_w0", {en_a, we_a, bank_a, addr_a, din_a}, {1'b1, 1'b1, 2'b11, 8'h00, 8'h10});
        chk("cmd_b_w1", {en_b, we_b, bank_b, addr_b, din_b}, {1'b1, 1'b1, 2'b11, 8'h01, 8'h11});
        step();
        req = '0;
        chk("cmd_a_w2", {en_a, we_a, bank_a, addr_a, din_a}, {1'b1, 1'b1, 2'b11, 8'h02, 8'h12});
        chk("cmd_b_w3", {en_b, we_b, bank_b, addr_b, din_b}, {1'b1, 1'b1, 2'b11, 8'h03, 8'h13});
        chk("ptr_after_wrap", dut.rr_ptr, 2'd0);

        set_req(2, 1'b1, 10'h1C3, 8'hA5);
        #1;
        chk("wr_gnt", gnt, 4'b0100);
        step();
        req = '0;
        chk("wr_cmd_a", {en_a, we_a, bank_a, addr_a, din_a}, {1'b1, 1'b1, 2'b01, 8'hC3, 8'hA5});
        chk("wr_cmd_b_idle", en_b, 1'b0);
        step();
        set_req(0, 1'b0, 10'h1C3, 8'h00);
        #1;
        chk("rd_gnt", gnt, 4'b0001);
        push(0, 8'hA5);
        step();
        req = '0;
        step();

        set_req(1, 1'b0, 10'h2A0, 8'h00);
        set_req(3, 1'b0, 10'h2FF, 8'h00);
        #1;
        chk("dual_rd_gnt", gnt, 4'b1010);
        push(1, 8'h11);
        push(3, 8'h22);
        step();
        req = '0;
        chk("dual_cmd_a", {en_a, we_a, bank_a, addr_a}, {1'b1, 1'b0, 2'b10, 8'hA0});
        chk("dual_cmd_b", {en_b, we_b, bank_b, addr_b}, {1'b1, 1'b0, 2'b10, 8'hFF});
        repeat (2) step();

        set_req(0, 1'b1, 10'h005, 8'h3C);
        set_req(1, 1'b0, 10'h005, 8'h00);
        #1;
        chk("conflict_gnt", gnt, 4'b0001);
        step();
        req[0] = 1'b0;
        #1;
        chk("deferred_gnt", gnt, 4'b0010);
        push(1, 8'h3C);
        step();
        req = '0;
        repeat (2) step();

        set_req(3, 1'b0, 10'h2FF, 8'h00);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("solo_gnt", gnt, 4'b1000);
            push(3, 8'h22);
            step();
            chk("solo_en", {en_a, en_b}, 2'b10);
            chk("solo_ptr", dut.rr_ptr, 2'd0);
        end
        req = '0;
        repeat (4) step();

        set_req(1, 1'b0, 10'h2A0, 8'h00);
        #1;
        chk("pre_rst_gnt", gnt, 4'b0010);
        step();
        req   = '0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        repeat (3) begin
            step();
            chk_all_zero("midrst_hold");
        end
        set_req(1, 1'b0, 10'h2A0, 8'h00);
        set_req(2, 1'b0, 10'h2A0, 8'h00);
        set_req(3, 1'b0, 10'h2A0, 8'h00);
        #1;
        chk("rst_gnt_gated", gnt, 4'b0000);
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_gnt", gnt, 4'b0110);
        push(1, 8'h11);
        push(2, 8'h11);
        step();
        req = '0;
        repeat (5) step();

        chk("scoreboard_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
